hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Multi-cycle multiply/divide unit with the architectural HI/LO register pair, located in the EXE stage. It executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO/MFHI/MFLO in a single cycle. While an iteration is in progress it stalls the pipeline. The MFHI/MFLO value travels with the instruction into MEM as ordinary `exe_data`.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Fixed at 32 for MIPS-I; the parameter exists only for reduced-width bench runs.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `valid` in 1: the EXE slot holds a live instruction.
- `write` in 1: the EXE→MEM pipeline register advances this cycle.
- `flush` in 1: exception/eret flush of EXE; kills the current op.
- `op` in 4: `hilo_op` code from the shared package.
- `rs_data` in 32: dividend, multiplicand, or MTHI/MTLO source.
- `rt_data` in 32: divisor or multiplier.
- `hilo_data` out 32: HI for MFHI, LO for MFLO, 0 otherwise. Combinational.
- `stall_out` out 1: hold IF/ID/EXE; MEM receives a bubble.
- `busy` out 1: state is not IDLE (debug/perf).

## Operation
- Op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. Codes 9–15 behave as NOP.
- A multi-cycle op starts when `valid & !flush` and the op is MULT, MULTU, DIV or DIVU while the state is IDLE.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL or IDLE→DIV on start. Operand magnitudes and the result sign are latched and `cnt`=0.
  - MUL/DIV perform one iteration per cycle, `cnt`++. After the iteration with `cnt`=31, go to DONE.
  - DONE: if `write` is high, HI/LO are updated at this edge and the next state is IDLE. Otherwise remain in DONE with results held in the accumulators.
  - `flush` in any state: go to IDLE, HI/LO unchanged.
- Multiply: radix-2 shift-add on 32-bit magnitudes into a 64-bit accumulator.
  - Signed: negate the 64-bit product if the operand signs differ.
  - Result: HI=product[63:32], LO=product[31:0].
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Signed: quotient is negative iff the signs differ; remainder takes the dividend's sign.
  - Result: LO=quotient, HI=remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divide by zero, signed or unsigned: LO=0xFFFFFFFF, HI=`rs_data`. No exception is raised.
- MTHI/MTLO: write HI/LO at the edge where `valid & write & !flush`.
- MFHI/MFLO: read the current registers. Because every HI/LO write lands at the edge where the producer leaves EXE, an adjacent consumer always reads updated values and no forwarding path is needed.

## Timing
- Reset values:
  - HI=LO=0, state IDLE, `cnt`=0.
  - `stall_out`=0, `busy`=0, `hilo_data`=0 (op treated as NOP).
- `stall_out` = `valid & !flush & is_muldiv & (state != DONE)`. It is combinational and high in the start cycle.
- Latency: start cycle (IDLE) + 32 iteration cycles + DONE = 34 cycles in EXE. `stall_out` is high for 33 cycles, then low in DONE.
- HI/LO are visible to the next instruction's MFHI/MFLO one cycle after the DONE edge.
- Reset has priority over flush, and flush has priority over start/update. Reset in mid-iteration returns to IDLE and clears HI/LO.
- While the state is not IDLE, `op`/`rs_data`/`rt_data` changes are ignored. The pipeline holds them stable under stall anyway.

## Structure
- Shared package `hilo_pkg`: `hilo_op` enum/localparams and the `HILO_ITER`=32 constant. The ID decoder imports the same codes.
- One sub-module, `iter_datapath`: holds the 64-bit accumulator and the shift/add/subtract step for both MUL and DIV, selected by a `mode` input. The FSM, sign fixup and HI/LO registers live in `hilo_muldiv`.

## Test plan
- Reset, then MFHI and MFLO: `hilo_data`=0 both times. `stall_out` stays 0.
- MULT 0xFFFFFFFE × 0x00000003 with `write`=1: `stall_out` high for exactly 33 cycles. After DONE, MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFA. MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- Signed DIV:
  - −7 / 2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU 5 / 0 gives LO=0xFFFFFFFF, HI=5.
- DIV with `write`=0 held for 4 extra cycles in DONE: HI/LO are unchanged until `write` rises, then update exactly once and the FSM returns to IDLE without restarting.
- `flush` asserted at `cnt`=10 of a MULT: next state IDLE, `stall_out` drops in the same cycle, and the previous HI/LO values are preserved.
- MTHI 0x12345678 followed immediately by MFHI: `hilo_data`=0x12345678 with zero stall. An MTLO together with `flush` does not modify LO.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared HI/LO operation codes and iteration constants. The ID decoder
// imports the same package so op encodings stay in one place.
package hilo_pkg;

    localparam int HILO_ITER = 32;

    typedef enum logic [3:0] {
        HILO_NOP   = 4'd0,
        HILO_MULT  = 4'd1,
        HILO_MULTU = 4'd2,
        HILO_DIV   = 4'd3,
        HILO_DIVU  = 4'd4,
        HILO_MTHI  = 4'd5,
        HILO_MTLO  = 4'd6,
        HILO_MFHI  = 4'd7,
        HILO_MFLO  = 4'd8
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } hilo_state_e;

    // Codes 9-15 fall outside every range here and therefore act as NOP.
    function automatic logic op_is_muldiv(input logic [3:0] op);
        return (op == HILO_MULT) || (op == HILO_MULTU) ||
               (op == HILO_DIV)  || (op == HILO_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_iter_datapath.sv
// Shared iterative datapath: a 2*WIDTH accumulator stepped once per cycle.
// mode=0: radix-2 shift-add multiply, acc = {partial, multiplier}.
// mode=1: restoring divide, acc = {remainder, dividend/quotient}.
// Operands are unsigned magnitudes; sign handling lives in the parent.
module iter_datapath
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_ITER
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   operand_q;
    logic               mode_q;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_next;

    // Next-accumulator values for one multiply step and one divide step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, operand_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder shifted left by one needs an extra bit before the trial
        // subtract; the MSB of diff is the borrow.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, operand_q};
        if (diff[WIDTH])
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Accumulator: load operands on start, then advance one step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            operand_q <= '0;
            mode_q    <= 1'b0;
        end else if (load) begin
            mode_q <= mode;
            if (mode) begin
                acc_q     <= {{WIDTH{1'b0}}, op_a};
                operand_q <= op_b;
            end else begin
                acc_q     <= {{WIDTH{1'b0}}, op_b};
                operand_q <= op_a;
            end
        end else if (step) begin
            acc_q <= mode_q ? div_next : mul_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv.sv
// EXE-stage multiply/divide unit with the architectural HI/LO pair.
// Multi-cycle ops stall the pipeline until DONE; HI/LO are written at the
// edge where the producing instruction leaves EXE, so no forwarding exists.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no op in flight; single-cycle HI/LO moves handled here
// MUL     | shift-add iteration, cnt counts 0..WIDTH-1
// DIV     | restoring-divide iteration, cnt counts 0..WIDTH-1
// DONE    | result ready, waiting for write to commit HI/LO
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             write,
    input  logic             flush,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hilo_data,
    output logic             stall_out,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    hilo_state_e      state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] dividend_q;

    logic             is_muldiv;
    logic             is_signed;
    logic             is_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             start;
    logic             iterating;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Decode and operand magnitudes for the start cycle.
    always_comb begin
        is_muldiv = op_is_muldiv(op);
        is_signed = (op == HILO_MULT) || (op == HILO_DIV);
        is_div    = (op == HILO_DIV)  || (op == HILO_DIVU);
        a_neg     = is_signed & rs_data[WIDTH-1];
        b_neg     = is_signed & rt_data[WIDTH-1];
        a_mag     = a_neg ? -rs_data : rs_data;
        b_mag     = b_neg ? -rt_data : rt_data;
        start     = (state_q == ST_IDLE) & valid & ~flush & is_muldiv;
        iterating = (state_q == ST_MUL) | (state_q == ST_DIV);
    end

    iter_datapath #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .load  (start),
        .step  (iterating),
        .mode  (is_div),
        .op_a  (a_mag),
        .op_b  (b_mag),
        .acc   (acc)
    );

    // Sign fixup of the unsigned accumulator into the HI/LO result.
    always_comb begin
        prod_fix = neg_res_q ? -acc : acc;
        quo_fix  = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
            res_hi = dividend_q;
            res_lo = '1;
        end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end
    end

    // Sequencing FSM: start, iterate WIDTH times, hold in DONE until write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= is_div ? ST_DIV : ST_MUL;
                        cnt_q      <= '0;
                        is_div_q   <= is_div;
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= is_div & (rt_data == '0);
                        dividend_q <= rs_data;
                    end
                end
                ST_MUL, ST_DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (write)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Architectural HI/LO: committed on the edge the producer leaves EXE.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!flush) begin
            if ((state_q == ST_DONE) && write) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (valid && write && (op == HILO_MTHI)) begin
                hi_q <= rs_data;
            end else if (valid && write && (op == HILO_MTLO)) begin
                lo_q <= rs_data;
            end
        end
    end

    // Outputs: read mux and stall/busy flags.
    always_comb begin
        if (op == HILO_MFHI)
            hilo_data = hi_q;
        else if (op == HILO_MFLO)
            hilo_data = lo_q;
        else
            hilo_data = '0;
        stall_out = valid & ~flush & is_muldiv & (state_q != ST_DONE);
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: reset, mul/div results, DONE hold,
// flush, single-cycle moves and reset during iteration.
module tb_hilo_muldiv;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        write;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hilo_data;
    logic        stall_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .write     (write),
        .flush     (flush),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .hilo_data (hilo_data),
        .stall_out (stall_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        valid   = 1'b0;
        write   = 1'b1;
        flush   = 1'b0;
        op      = HILO_NOP;
        rs_data = '0;
        rt_data = '0;
    endtask

    // One MFHI/MFLO in EXE for a single cycle.
    task automatic read_reg(input logic [3:0] rop, output logic [31:0] val,
                            output logic st);
        valid = 1'b1;
        write = 1'b1;
        op    = rop;
        #1;
        val = hilo_data;
        st  = stall_out;
        tick();
        valid = 1'b0;
        op    = HILO_NOP;
    endtask

    // Issue a multi-cycle op with write=1 and let it complete.
    task automatic run_op(input logic [3:0] mop, input logic [31:0] a,
                          input logic [31:0] b, output int stall_cycles);
        valid   = 1'b1;
        write   = 1'b1;
        op      = mop;
        rs_data = a;
        rt_data = b;
        stall_cycles = 0;
        #1;
        while (stall_out && stall_cycles < 40) begin
            stall_cycles++;
            tick();
        end
        tick();
        valid = 1'b0;
        op    = HILO_NOP;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic        st;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b expected 0", busy);
        end
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b expected 0", stall_out);
        end
        checks++;
        if (hilo_data !== 32'h0) begin
            errors++; $display("FAIL reset_hilo_data got %h expected 00000000", hilo_data);
        end
        rst = 1'b0;
        read_reg(HILO_MFHI, v, st);
        checks++;
        if (v !== 32'h0 || st !== 1'b0) begin
            errors++; $display("FAIL reset_mfhi got %h/%b expected 00000000/0", v, st);
        end
        read_reg(HILO_MFLO, v, st);
        checks++;
        if (v !== 32'h0 || st !== 1'b0) begin
            errors++; $display("FAIL reset_mflo got %h/%b expected 00000000/0", v, st);
        end
    endtask

    task automatic test_mult;
        logic [3:0]  t_op [2];
        logic [31:0] t_hi [2];
        logic [31:0] t_lo [2];
        logic [31:0] v;
        logic        st;
        int          n;
        t_op[0] = HILO_MULT;  t_hi[0] = 32'hFFFFFFFF; t_lo[0] = 32'hFFFFFFFA;
        t_op[1] = HILO_MULTU; t_hi[1] = 32'h00000002; t_lo[1] = 32'hFFFFFFFA;
        for (int i = 0; i < 2; i++) begin
            run_op(t_op[i], 32'hFFFFFFFE, 32'h00000003, n);
            checks++;
            if (n != 33) begin
                errors++; $display("FAIL mult%0d_stall_cycles got %0d expected 33", i, n);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL mult%0d_busy_after got %b expected 0", i, busy);
            end
            read_reg(HILO_MFHI, v, st);
            checks++;
            if (v !== t_hi[i]) begin
                errors++; $display("FAIL mult%0d_hi got %h expected %h", i, v, t_hi[i]);
            end
            read_reg(HILO_MFLO, v, st);
            checks++;
            if (v !== t_lo[i]) begin
                errors++; $display("FAIL mult%0d_lo got %h expected %h", i, v, t_lo[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [3:0]  t_op [4];
        logic [31:0] t_a  [4];
        logic [31:0] t_b  [4];
        logic [31:0] t_hi [4];
        logic [31:0] t_lo [4];
        logic [31:0] v;
        logic        st;
        int          n;
        t_op[0] = HILO_DIV;  t_a[0] = 32'hFFFFFFF9; t_b[0] = 32'h00000002;
        t_hi[0] = 32'hFFFFFFFF; t_lo[0] = 32'hFFFFFFFD;
        t_op[1] = HILO_DIV;  t_a[1] = 32'h80000000; t_b[1] = 32'hFFFFFFFF;
        t_hi[1] = 32'h00000000; t_lo[1] = 32'h80000000;
        t_op[2] = HILO_DIV;  t_a[2] = 32'hFFFFFFF9; t_b[2] = 32'h00000000;
        t_hi[2] = 32'hFFFFFFF9; t_lo[2] = 32'hFFFFFFFF;
        t_op[3] = HILO_DIVU; t_a[3] = 32'h00000005; t_b[3] = 32'h00000000;
        t_hi[3] = 32'h00000005; t_lo[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], n);
            checks++;
            if (n != 33) begin
                errors++; $display("FAIL div%0d_stall_cycles got %0d expected 33", i, n);
            end
            read_reg(HILO_MFHI, v, st);
            checks++;
            if (v !== t_hi[i]) begin
                errors++; $display("FAIL div%0d_hi got %h expected %h", i, v, t_hi[i]);
            end
            read_reg(HILO_MFLO, v, st);
            checks++;
            if (v !== t_lo[i]) begin
                errors++; $display("FAIL div%0d_lo got %h expected %h", i, v, t_lo[i]);
            end
        end
    endtask

    // DIV 100/7 with write held low in DONE; HI/LO start at 5 / FFFFFFFF.
    task automatic test_done_hold;
        logic [31:0] v;
        logic        st;
        int          n;
        valid   = 1'b1;
        write   = 1'b0;
        op      = HILO_DIV;
        rs_data = 32'd100;
        rt_data = 32'd7;
        n = 0;
        #1;
        while (stall_out && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 33) begin
            errors++; $display("FAIL hold_stall_cycles got %0d expected 33", n);
        end
        for (int i = 0; i < 4; i++) begin
            op = HILO_MFHI;
            #1;
            checks++;
            if (hilo_data !== 32'h00000005 || busy !== 1'b1) begin
                errors++; $display("FAIL hold%0d_hi got %h/%b expected 00000005/1", i, hilo_data, busy);
            end
            op = HILO_MFLO;
            #1;
            checks++;
            if (hilo_data !== 32'hFFFFFFFF) begin
                errors++; $display("FAIL hold%0d_lo got %h expected ffffffff", i, hilo_data);
            end
            tick();
        end
        op    = HILO_DIV;
        write = 1'b1;
        #1;
        tick();
        valid = 1'b0;
        op    = HILO_NOP;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL hold_release_busy got %b expected 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL hold_no_restart got %b expected 0", busy);
        end
        read_reg(HILO_MFHI, v, st);
        checks++;
        if (v !== 32'd2) begin
            errors++; $display("FAIL hold_hi got %h expected 00000002", v);
        end
        read_reg(HILO_MFLO, v, st);
        checks++;
        if (v !== 32'd14) begin
            errors++; $display("FAIL hold_lo got %h expected 0000000e", v);
        end
    endtask

    // Flush a MULT at cnt=10; HI/LO (2 / 14) must survive.
    task automatic test_flush;
        logic [31:0] v;
        logic        st;
        valid   = 1'b1;
        write   = 1'b1;
        op      = HILO_MULT;
        rs_data = 32'd3;
        rt_data = 32'd4;
        #1;
        tick();
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1 || stall_out !== 1'b1) begin
            errors++; $display("FAIL flush_pre got %b/%b expected 1/1", busy, stall_out);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL flush_stall_drop got %b expected 0", stall_out);
        end
        tick();
        flush = 1'b0;
        valid = 1'b0;
        op    = HILO_NOP;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle got %b expected 0", busy);
        end
        read_reg(HILO_MFHI, v, st);
        checks++;
        if (v !== 32'd2) begin
            errors++; $display("FAIL flush_hi got %h expected 00000002", v);
        end
        read_reg(HILO_MFLO, v, st);
        checks++;
        if (v !== 32'd14) begin
            errors++; $display("FAIL flush_lo got %h expected 0000000e", v);
        end
    endtask

    task automatic test_moves;
        valid   = 1'b1;
        write   = 1'b1;
        op      = HILO_MTHI;
        rs_data = 32'h12345678;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++; $display("FAIL mthi_stall got %b expected 0", stall_out);
        end
        tick();
        op = HILO_MFHI;
        #1;
        checks++;
        if (hilo_data !== 32'h12345678 || stall_out !== 1'b0) begin
            errors++; $display("FAIL mthi_mfhi got %h/%b expected 12345678/0", hilo_data, stall_out);
        end
        tick();
        op      = HILO_MTLO;
        rs_data = 32'hDEADBEEF;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        op    = HILO_MFLO;
        #1;
        checks++;
        if (hilo_data !== 32'd14) begin
            errors++; $display("FAIL mtlo_flush got %h expected 0000000e", hilo_data);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        logic        st;
        valid   = 1'b1;
        write   = 1'b1;
        op      = HILO_MULT;
        rs_data = 32'd5;
        rt_data = 32'd5;
        #1;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_busy got %b expected 0", busy);
        end
        read_reg(HILO_MFHI, v, st);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL rstmid_hi got %h expected 00000000", v);
        end
        read_reg(HILO_MFLO, v, st);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL rstmid_lo got %h expected 00000000", v);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_div();
        test_done_hold();
        test_flush();
        test_moves();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
